// File: rtl/fmt_pkg.sv
// rtl/fmt_pkg.sv - shared opcodes, format classes, FSM states and counter sizing
package fmt_pkg;

  localparam int NUM_FMT = 6;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Class value doubles as the per-unit bit position on the issue/done buses.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_U = 3'd3,
    FMT_B = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Counter must hold 0..timeout; keep at least one bit when the timeout is disabled.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fmt_decode.sv
// rtl/fmt_decode.sv - opcode to format class, legality and masked register fields
module fmt_decode
  import fmt_pkg::*;
(
  input  logic [31:0] instr,
  output fmt_e        fmt,
  output logic        legal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  // Function and immediate bits play no part in steering.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

  // Classify the opcode and zero the register fields the format does not use.
  always_comb begin
    fmt   = FMT_R;
    legal = 1'b1;
    rd    = instr[11:7];
    rs1   = instr[19:15];
    rs2   = instr[24:20];
    case (instr[6:0])
      OP_REG: begin
        fmt = FMT_R;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        rs2 = 5'd0;
      end
      OP_STORE: begin
        fmt = FMT_S;
        rd  = 5'd0;
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        rs1 = 5'd0;
        rs2 = 5'd0;
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        rd  = 5'd0;
      end
      OP_JAL: begin
        fmt = FMT_J;
        rs1 = 5'd0;
        rs2 = 5'd0;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/format_dispatch_unit.sv
// rtl/format_dispatch_unit.sv - handshaked dispatch of one instruction to its format unit
module format_dispatch_unit
  import fmt_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    iVALID,
  output logic                    oREADY,
  input  logic [31:0]             iINSTR,
  input  logic [XLEN-1:0]         iALU_IN1,
  input  logic [XLEN-1:0]         iALU_IN2,
  output logic [4:0]              oRD,
  output logic [4:0]              oRS1,
  output logic [4:0]              oRS2,
  output logic [2:0]              oFMT,
  output logic [NUM_FMT-1:0]      oUNIT_VALID,
  input  logic [NUM_FMT-1:0]      iUNIT_READY,
  output logic [XLEN-1:0]         oUNIT_IN1,
  output logic [XLEN-1:0]         oUNIT_IN2,
  input  logic [NUM_FMT-1:0]      iUNIT_DONE,
  input  logic [NUM_FMT*XLEN-1:0] iUNIT_OUT,
  output logic [XLEN-1:0]         oALU_OUT,
  output logic                    oRESULT_VALID,
  input  logic                    iRESULT_READY,
  output logic                    oILLEGAL,
  output logic                    oTIMEOUT
);

  localparam int CW = cnt_width(TIMEOUT);
  // Counter value seen during the last cycle allowed in ISSUE+WAIT.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  fmt_e              fmt_q, fmt_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [XLEN-1:0]   in1_q, in1_d;
  logic [XLEN-1:0]   in2_q, in2_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  fmt_e              dec_fmt;
  logic              dec_legal;
  logic [4:0]        dec_rd, dec_rs1, dec_rs2;

  logic [NUM_FMT-1:0] unit_sel;
  logic               sel_ready;
  logic               sel_done;
  logic [XLEN-1:0]    sel_out;
  logic               timeout_hit;
  logic               busy;

  fmt_decode u_decode (
    .instr (iINSTR),
    .fmt   (dec_fmt),
    .legal (dec_legal),
    .rd    (dec_rd),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2)
  );

  // Only the latched class's unit is ever looked at; the others are don't-care.
  always_comb begin
    unit_sel  = NUM_FMT'(1) << fmt_q;
    sel_ready = |(iUNIT_READY & unit_sel);
    sel_done  = |(iUNIT_DONE & unit_sel);
    sel_out   = '0;
    for (int k = 0; k < NUM_FMT; k++) begin
      if (unit_sel[k]) begin
        sel_out = iUNIT_OUT[k*XLEN +: XLEN];
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Next-state, operand/field latching, timeout counting and result capture.
  always_comb begin
    state_d   = state_q;
    fmt_d     = fmt_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iVALID) begin
          fmt_d     = dec_fmt;
          rd_d      = dec_rd;
          rs1_d     = dec_rs1;
          rs2_d     = dec_rs2;
          in1_d     = iALU_IN1;
          in2_d     = iALU_IN2;
          alu_d     = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          illegal_d = ~dec_legal;
          state_d   = dec_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_hit) begin
          timeout_d = 1'b1;
          alu_d     = '0;
          state_d   = ST_RESP;
        end else if (sel_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the final allowed cycle beats the timeout.
        if (sel_done) begin
          alu_d   = sel_out;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          alu_d     = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (iRESULT_READY) begin
          illegal_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers; reset drops any in-flight transaction silently.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      fmt_q     <= FMT_R;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fmt_q     <= fmt_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs decoded from state so the issue strobe drops the cycle the FSM leaves ISSUE.
  always_comb begin
    oREADY        = (state_q == ST_IDLE);
    oRESULT_VALID = (state_q == ST_RESP);
    oUNIT_VALID   = (state_q == ST_ISSUE) ? unit_sel : '0;
    oUNIT_IN1     = busy ? in1_q : '0;
    oUNIT_IN2     = busy ? in2_q : '0;
    oALU_OUT      = alu_q;
    oRD           = rd_q;
    oRS1          = rs1_q;
    oRS2          = rs2_q;
    oFMT          = fmt_q;
    oILLEGAL      = illegal_q;
    oTIMEOUT      = timeout_q;
  end

endmodule

// File: doc/format_dispatch_unit.md
# format_dispatch_unit

Handshaked, registered successor to the core's combinational opcode steering logic. It accepts one instruction with its two ALU operands, decodes the opcode into a format class (R/I/S/U/B/J), and latches format-correct rd/rs1/rs2. It issues the operands to the matching per-format execution unit, waits for that unit's result, and returns the result with a valid/ready handshake. Illegal opcodes and hung units are reported instead of silently producing 0. It sits between the decode stage and the per-format ALUs.

## Interface
Parameters:
- XLEN, 32, operand/result width
- TIMEOUT, 16, max cycles in ISSUE+WAIT before abort; 0 disables timeout

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- iVALID  in  1  instruction/operands valid
- oREADY  out  1  unit can accept (high only in IDLE)
- iINSTR  in  32  instruction word
- iALU_IN1, iALU_IN2  in  XLEN  operands
- oRD, oRS1, oRS2  out  5  latched register indices, masked per format
- oFMT  out  3  latched format class
- oUNIT_VALID  out  6  one-hot issue strobe, bit = format class
- iUNIT_READY  in  6  per-unit accept
- oUNIT_IN1, oUNIT_IN2  out  XLEN  shared operand bus to units
- iUNIT_DONE  in  6  per-unit result strobe
- iUNIT_OUT  in  6*XLEN  per-unit results, slice k = class k
- oALU_OUT  out  XLEN  selected result
- oRESULT_VALID  out  1  result available
- iRESULT_READY  in  1  consumer accepts result
- oILLEGAL, oTIMEOUT  out  1  status qualifying oALU_OUT

## Operation
- Classes: R=0 (0110011); I=1 (0010011, 0000011, 1100111); S=2 (0100011); U=3 (0110111, 0010111); B=4 (1100011); J=5 (1101111). Any other opcode is illegal.
- Fields: rd=iINSTR[11:7], rs1=[19:15], rs2=[24:20]. Masking: I forces rs2=0. S/B force rd=0. U/J force rs1=rs2=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: oREADY=1. On iVALID, latch fields, oFMT, and operands; clear the timeout counter. A legal opcode goes to ISSUE. An illegal opcode goes to RESP with oILLEGAL=1 and oALU_OUT=0.
  - ISSUE: oUNIT_VALID[k]=1 for the latched class k only. iUNIT_READY[k] moves to WAIT. iUNIT_DONE is ignored in ISSUE.
  - WAIT: iUNIT_DONE[k] captures iUNIT_OUT[k*XLEN +: XLEN] into oALU_OUT and moves to RESP.
  - RESP: oRESULT_VALID=1. oALU_OUT, flags, oRD/oRS1/oRS2 and oFMT stay stable. iRESULT_READY moves to IDLE and clears oRESULT_VALID, oILLEGAL and oTIMEOUT.
- Done/ready bits of non-selected units are ignored in every state.
- oUNIT_IN1/2 carry latched operands in ISSUE and WAIT, and are 0 otherwise.
- Timeout (TIMEOUT>0): the counter increments each cycle in ISSUE/WAIT. If no done arrives by the TIMEOUT-th such cycle, go to RESP with oTIMEOUT=1 and oALU_OUT=0. oUNIT_VALID drops immediately.
- Done and timeout in the same cycle: done wins and oTIMEOUT=0.

## Timing
- Reset values: state IDLE, oREADY=1. All other outputs are 0: oUNIT_VALID, oUNIT_IN*, oALU_OUT, oRD/oRS1/oRS2, oFMT, oRESULT_VALID, oILLEGAL, oTIMEOUT.
- Reset mid-operation aborts the transaction with no result and no flag. A unit still busy must tolerate the abort.
- Accept at cycle T. Legal path: ISSUE at T+1. If ready at T+1, WAIT at T+2. Done at T+2 gives RESP at T+3. Minimum latency is 3 cycles.
- Illegal opcode: RESP at T+1.
- Timeout: with no ready or done, RESP at T+TIMEOUT+1.
- No accept while busy. oREADY rises the cycle after the RESP handshake, so peak throughput is one instruction per 4 cycles.
- The consumer may hold iRESULT_READY high; the handshake then completes in the first RESP cycle.

## Structure
- Package fmt_pkg holds:
  - opcode constants
  - format class encoding and NUM_FMT=6
  - FSM state encoding
  - timeout counter width helper ($clog2(TIMEOUT+1))
- Sub-module fmt_decode (combinational): opcode → class, legal flag, masked rd/rs1/rs2.
- The top holds the FSM, latches, counter and result capture.

## Test plan
- ADD (0x002081B3), operands 5/7, unit R ready at T+1, done at T+2 with 12 → oUNIT_VALID=000001 at T+1; oALU_OUT=12, oRD=3, oRS1=1, oRS2=2 at T+3; flags 0.
- SW (opcode 0100011) → oUNIT_VALID=000100, oRD=0. LUI (0110111) → class 3, rs1=rs2=0.
- Opcode 1111111 → no oUNIT_VALID; oILLEGAL=1, oALU_OUT=0, oRESULT_VALID=1 at T+1.
- TIMEOUT=4, J unit never done → oTIMEOUT=1 at T+5, oUNIT_VALID drops. Same case with done on the 4th cycle → result returned, oTIMEOUT=0.
- Spurious iUNIT_DONE[0] during an I-class WAIT is ignored. Hold iRESULT_READY=0 for 3 cycles → output stable, oREADY=0. A new iVALID is not accepted until after the handshake.
- RST_N low while in WAIT → all outputs return to reset values next cycle, oREADY=1; the next instruction is processed normally.
